// File: rtl/kernel_cra_bridge.sv
// Host Avalon-MM slave that forwards single-word MMIO accesses to a kernel CRA master,
// one transaction at a time, with a timeout/abort path so the host can never stall.
module kernel_cra_bridge #(
   parameter int unsigned           ADDR_WIDTH     = 30,
   parameter int unsigned           DATA_WIDTH     = 64,
   parameter int unsigned           BYTEEN_WIDTH   = 8,
   parameter int unsigned           TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 64'hDEAD_BEEF_DEAD_BEEF,
   parameter int unsigned           CNT_WIDTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    kernel_reset_n,
   input  logic [ADDR_WIDTH-1:0]   h_address,
   input  logic                    h_read,
   input  logic                    h_write,
   input  logic [DATA_WIDTH-1:0]   h_writedata,
   input  logic [BYTEEN_WIDTH-1:0] h_byteenable,
   output logic                    h_waitrequest,
   output logic [DATA_WIDTH-1:0]   h_readdata,
   output logic                    h_readdatavalid,
   output logic [ADDR_WIDTH-1:0]   kernel_cra_address,
   output logic                    kernel_cra_read,
   output logic                    kernel_cra_write,
   output logic [DATA_WIDTH-1:0]   kernel_cra_writedata,
   output logic [BYTEEN_WIDTH-1:0] kernel_cra_byteenable,
   output logic                    kernel_cra_burstcount,
   output logic                    kernel_cra_debugaccess,
   input  logic                    kernel_cra_waitrequest,
   input  logic [DATA_WIDTH-1:0]   kernel_cra_readdata,
   input  logic                    kernel_cra_readdatavalid,
   output logic                    timeout_pulse,
   output logic [CNT_WIDTH-1:0]    timeout_count
);

   localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);
   localparam logic [TimerWidth-1:0] TimerMax = TimerWidth'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StRdWait, StDone} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [BYTEEN_WIDTH-1:0] be_q, be_d;
   logic                    is_read_q, is_read_d;
   logic [TimerWidth-1:0]   timer_q, timer_d;
   logic                    stale_q, stale_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rvalid_q, rvalid_d;
   logic [CNT_WIDTH-1:0]    tcount_q, tcount_d;
   logic                    issue, accepted, timer_expired, abort;

   // A read waits with its strobe low while a late response from an aborted read is owed.
   assign issue         = (state_q == StReq) && !(is_read_q && stale_q);
   assign accepted      = issue && !kernel_cra_waitrequest;
   assign timer_expired = (timer_q == TimerMax);

   assign kernel_cra_read        = issue && is_read_q;
   assign kernel_cra_write       = issue && !is_read_q;
   assign kernel_cra_address     = addr_q;
   assign kernel_cra_writedata   = wdata_q;
   assign kernel_cra_byteenable  = be_q;
   assign kernel_cra_burstcount  = 1'b1;
   assign kernel_cra_debugaccess = 1'b0;
   assign h_waitrequest          = (state_q != StIdle);
   assign h_readdata             = rdata_q;
   assign h_readdatavalid        = rvalid_q;
   assign timeout_count          = tcount_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      be_d          = be_q;
      is_read_d     = is_read_q;
      timer_d       = timer_q;
      stale_d       = stale_q;
      rdata_d       = rdata_q;
      rvalid_d      = 1'b0;
      tcount_d      = tcount_q;
      abort         = 1'b0;
      timeout_pulse = 1'b0;

      if (stale_q && kernel_cra_readdatavalid) stale_d = 1'b0;
      if ((state_q == StReq || state_q == StRdWait) && !timer_expired) begin
         timer_d = timer_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (h_read || h_write) begin
               addr_d    = h_address;
               wdata_d   = h_writedata;
               be_d      = h_byteenable;
               is_read_d = h_read;
               timer_d   = '0;
               if (kernel_reset_n) begin
                  state_d = StReq;
               end else begin
                  state_d = StDone;
                  if (h_read) begin
                     rvalid_d = 1'b1;
                     rdata_d  = TIMEOUT_DATA;
                  end
               end
            end
         end
         StReq: begin
            if (accepted) begin
               if (!is_read_q) begin
                  state_d = StIdle;
               end else if (kernel_cra_readdatavalid) begin
                  rvalid_d = 1'b1;
                  rdata_d  = kernel_cra_readdata;
                  state_d  = StIdle;
               end else begin
                  state_d = StRdWait;
               end
            end else if (timer_expired) begin
               abort = 1'b1;
            end
         end
         StRdWait: begin
            if (kernel_cra_readdatavalid) begin
               rvalid_d = 1'b1;
               rdata_d  = kernel_cra_readdata;
               state_d  = StIdle;
            end else if (timer_expired) begin
               abort   = 1'b1;
               stale_d = 1'b1;
            end
         end
         StDone: state_d = StIdle;
      endcase

      if (abort) begin
         timeout_pulse = 1'b1;
         state_d       = StIdle;
         if (tcount_q != '1) tcount_d = tcount_q + 1'b1;
         if (is_read_q) begin
            rvalid_d = 1'b1;
            rdata_d  = TIMEOUT_DATA;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         is_read_q <= 1'b0;
         timer_q   <= '0;
         stale_q   <= 1'b0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         tcount_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         is_read_q <= is_read_d;
         timer_q   <= timer_d;
         stale_q   <= stale_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         tcount_q  <= tcount_d;
      end
   end

endmodule
